// File: rtl/baud_pkg.sv
// Shared constants and types for the fractional baud generator.
// Reset divisor defaults, minimum legal divisor, divisor pair type.
package baud_pkg;

    localparam int DEF_DIV_INT  = 27;
    localparam int DEF_DIV_FRAC = 0;
    localparam int MIN_DIV      = 2;

    typedef struct packed {
        logic [31:0] div_int;
        logic [15:0] div_frac;
    } div_pair_t;

    function automatic logic div_ok(input logic [31:0] v);
        return v >= 32'(MIN_DIV);
    endfunction

endpackage

// File: rtl/mod_m_counter_en.sv
// Enabled modulo-M counter with synchronous clear.
// Ports: clk, reset (async high), clr, en -> q (index), max_tick (q==M-1).
module mod_m_counter_en #(
    parameter int M = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         max_tick
);

    logic [W-1:0] r;

    assign max_tick = (r == W'(M - 1));
    assign q        = r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r <= '0;
        else if (clr)
            r <= '0;
        else if (en)
            r <= max_tick ? '0 : r + W'(1);
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: sample_tick every div_int+div_frac/2^FRAC_W
// clocks on average, bit_tick every OSR sample ticks.
// Ports: clk, reset (async high), en, restart, load, div_int, div_frac
//   -> sample_tick, bit_tick, q (period count), bit_phase, cfg_err (sticky).
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OSR          = 16,
    parameter int OSR_W        = 4,
    parameter int DEF_DIV_INT  = baud_pkg::DEF_DIV_INT,
    parameter int DEF_DIV_FRAC = baud_pkg::DEF_DIV_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              restart,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              sample_tick,
    output logic              bit_tick,
    output logic [DIV_W-1:0]  q,
    output logic [OSR_W-1:0]  bit_phase,
    output logic              cfg_err
);

    import baud_pkg::*;

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              extra;
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;
    logic              pend;
    logic              err_q;

    logic [DIV_W-1:0]  last;
    logic              load_ok;
    logic              apply;
    logic              os_last;

    assign last    = act_int - DIV_W'(1) + DIV_W'(extra);
    assign load_ok = load & div_ok(32'(div_int));

    // >= rather than == so a divisor that shrank while frozen
    // cannot leave cnt stranded past the end of the period.
    assign sample_tick = en & ~restart & (cnt >= last);

    // Divisor switches only at period boundaries (or while frozen).
    assign apply = restart | sample_tick | ~en;

    assign q        = cnt;
    assign bit_tick = sample_tick & os_last;
    assign cfg_err  = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            extra    <= 1'b0;
            act_int  <= DIV_W'(DEF_DIV_INT);
            act_frac <= FRAC_W'(DEF_DIV_FRAC);
            sh_int   <= DIV_W'(DEF_DIV_INT);
            sh_frac  <= FRAC_W'(DEF_DIV_FRAC);
            pend     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (restart) begin
                cnt   <= '0;
                acc   <= '0;
                extra <= 1'b0;
            end else if (sample_tick) begin
                cnt          <= '0;
                // carry out stretches the next period by one clock
                {extra, acc} <= {1'b0, acc} + {1'b0, act_frac};
            end else if (en) begin
                cnt <= cnt + DIV_W'(1);
            end

            if (load & ~load_ok)
                err_q <= 1'b1;

            if (load_ok) begin
                sh_int  <= div_int;
                sh_frac <= div_frac;
            end

            if (apply) begin
                if (load_ok) begin
                    act_int  <= div_int;
                    act_frac <= div_frac;
                end else if (pend) begin
                    act_int  <= sh_int;
                    act_frac <= sh_frac;
                end
                pend <= 1'b0;
            end else if (load_ok) begin
                pend <= 1'b1;
            end
        end
    end

    mod_m_counter_en #(
        .M (OSR),
        .W (OSR_W)
    ) u_os_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (restart),
        .en       (sample_tick),
        .q        (bit_phase),
        .max_tick (os_last)
    );

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac (OSR=4, default divisor 4.0).
// Directed scenarios followed by randomized stimulus against a model.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 4;
    localparam int OSR_W  = 2;
    localparam int DEFI   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              restart;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              sample_tick;
    logic              bit_tick;
    logic [DIV_W-1:0]  q;
    logic [OSR_W-1:0]  bit_phase;
    logic              cfg_err;

    baud_gen_frac #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .OSR          (OSR),
        .OSR_W        (OSR_W),
        .DEF_DIV_INT  (DEFI),
        .DEF_DIV_FRAC (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .restart     (restart),
        .load        (load),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .sample_tick (sample_tick),
        .bit_tick    (bit_tick),
        .q           (q),
        .bit_phase   (bit_phase),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current period, period
    // length, tick count, cumulative fractional sum since restart.
    int     m_pos, m_len, m_ph, m_ai, m_af, m_si, m_sf, m_extra;
    bit     m_pend, m_err;
    longint m_f;

    int cyc;
    int first_bit;
    int tick_log[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_ph = 0; m_f = 0; m_extra = 0;
        m_ai = DEFI; m_af = 0; m_si = DEFI; m_sf = 0;
        m_pend = 0; m_err = 0; m_len = DEFI;
    endtask

    task automatic model_edge(input bit t);
        bit     ok;
        longint oldf;
        ok = load && (div_int >= 2);
        if (load && !ok) m_err = 1;
        if (restart) begin
            m_pos = 0; m_ph = 0; m_f = 0; m_extra = 0;
        end else if (t) begin
            m_pos = 0;
            m_ph = (m_ph + 1) % OSR;
            oldf = m_f;
            m_f = m_f + m_af;
            m_extra = int'(m_f / 16 - oldf / 16);
        end else if (en) begin
            m_pos++;
        end
        if (restart || t || !en) begin
            if (ok) begin
                m_ai = int'(div_int); m_af = int'(div_frac);
            end else if (m_pend) begin
                m_ai = m_si; m_af = m_sf;
            end
            m_pend = 0;
        end else if (ok) begin
            m_pend = 1;
        end
        if (ok) begin
            m_si = int'(div_int); m_sf = int'(div_frac);
        end
        m_len = m_ai + m_extra;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        bit t, bt;
        t  = en && !restart && (m_pos == m_len - 1);
        bt = t && (m_ph == OSR - 1);
        #1;
        chk("q", 32'(q), 32'(m_pos));
        chk("sample_tick", 32'(sample_tick), 32'(t));
        chk("bit_tick", 32'(bit_tick), 32'(bt));
        chk("bit_phase", 32'(bit_phase), 32'(m_ph));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        if (sample_tick === 1'b1) tick_log.push_back(cyc);
        if (bit_tick === 1'b1 && first_bit < 0) first_bit = cyc;
        @(posedge clk);
        model_edge(t);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_for(input int qv, input int ph,
                            input bit use_ph, input string tag);
        int n = 0;
        while (!(int'(q) == qv && (!use_ph || int'(bit_phase) == ph))
               && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic chk_gap(input string tag, input int gap);
        chk({tag, "_seen"}, 32'(tick_log.size() >= 2), 32'd1);
        if (tick_log.size() >= 2)
            chk(tag, 32'(tick_log[1] - tick_log[0]), 32'(gap));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        reset = 1'b1; en = 1'b1; restart = 1'b0; load = 1'b0;
        div_int = '0; div_frac = '0;
        model_reset();
        first_bit = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_tick", 32'(sample_tick), 32'd0);
        chk("rst_bit", 32'(bit_tick), 32'd0);
        chk("rst_phase", 32'(bit_phase), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        cyc = 0;

        // div 4.0 from reset
        repeat (20) cycle();
        chk("tick0_cycle", 32'(tick_log[0]), 32'd3);
        chk("tick1_cycle", 32'(tick_log[1]), 32'd7);
        chk("tick2_cycle", 32'(tick_log[2]), 32'd11);
        chk("first_bit_cycle", 32'(first_bit), 32'd15);

        // div 4 + 8/16: 32 periods span 144 clocks
        load = 1'b1; div_int = 16'd4; div_frac = 4'd8;
        cycle();
        load = 1'b0;
        repeat (8) cycle();
        tick_log.delete();
        repeat (200) cycle();
        chk("frac_ticks_seen", 32'(tick_log.size() >= 33), 32'd1);
        if (tick_log.size() >= 33)
            chk("frac_span", 32'(tick_log[32] - tick_log[0]), 32'd144);

        // restart with load 4.0, then load 10 at cnt=1
        restart = 1'b1; load = 1'b1; div_int = 16'd4; div_frac = 4'd0;
        cycle();
        restart = 1'b0; load = 1'b0;
        wait_for(1, 0, 1'b0, "reach_cnt1");
        load = 1'b1; div_int = 16'd10;
        cycle();
        load = 1'b0;
        tick_log.delete();
        repeat (20) cycle();
        chk_gap("mid_load_gap", 10);

        // load coinciding with a tick
        wait_for(9, 0, 1'b0, "reach_cnt9");
        load = 1'b1; div_int = 16'd6;
        cycle();
        load = 1'b0;
        tick_log.delete();
        repeat (16) cycle();
        chk_gap("tick_load_gap", 6);

        // rejected divisor
        load = 1'b1; div_int = 16'd1;
        cycle();
        load = 1'b0;
        chk("err_set", 32'(cfg_err), 32'd1);
        tick_log.delete();
        repeat (16) cycle();
        chk_gap("err_gap", 6);
        load = 1'b1; div_int = 16'd5;
        cycle();
        load = 1'b0;
        repeat (14) cycle();
        chk("err_sticky", 32'(cfg_err), 32'd1);

        // freeze at cnt=2 for 7 cycles
        wait_for(2, 0, 1'b0, "reach_cnt2");
        en = 1'b0;
        repeat (7) cycle();
        chk("en_hold_q", 32'(q), 32'd2);
        en = 1'b1;
        tick_log.delete();
        c0 = cyc;
        repeat (5) cycle();
        chk("en_resume_seen", 32'(tick_log.size() >= 1), 32'd1);
        if (tick_log.size() >= 1)
            chk("en_resume", 32'(tick_log[0] - c0), 32'd2);

        // restart at cnt=3, os_cnt=2
        wait_for(3, 2, 1'b1, "reach_cnt3_ph2");
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        chk("restart_q", 32'(q), 32'd0);
        chk("restart_phase", 32'(bit_phase), 32'd0);
        tick_log.delete();
        c0 = cyc;
        repeat (10) cycle();
        chk("restart_first", 32'(tick_log[0] - c0), 32'd4);

        // async reset mid-period
        wait_for(2, 0, 1'b0, "reach_cnt2b");
        reset = 1'b1;
        #1;
        chk("areset_q", 32'(q), 32'd0);
        chk("areset_phase", 32'(bit_phase), 32'd0);
        chk("areset_err", 32'(cfg_err), 32'd0);
        chk("areset_tick", 32'(sample_tick), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // randomized traffic
        repeat (2000) begin
            en = m_pend ? 1'b1 : ($urandom % 16 != 0);
            restart = ($urandom % 40 == 0);
            load = en && ($urandom % 12 == 0);
            div_int = 16'($urandom_range(0, 9));
            div_frac = 4'($urandom % 16);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
